// File: rtl/fifo_queue_16_bit.sv
// fifo_queue_16_bit: single-clock FIFO, DEPTH x DATA_WIDTH, registered read data, count-decoded flags
//   Clk_In, Reset_In (async, active-high)       : clock / reset
//   Data_In, Write_Enable_In                    : write side
//   Data_Out, Read_Enable_In                    : read side, Data_Out loads one cycle after an accepted read
//   FIFO_Empty, FIFO_Full                       : status decoded from the occupancy count
//   Overflow_Out, Underflow_Out                 : rejected-request pulses, only with FIFO_QUEUE_ERR_FLAGS_EN defined
module fifo_queue_16_bit #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                  Clk_In,
  input  logic                  Reset_In,
  input  logic [DATA_WIDTH-1:0] Data_In,
  output logic [DATA_WIDTH-1:0] Data_Out,
  input  logic                  Write_Enable_In,
  input  logic                  Read_Enable_In,
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  output logic                  Overflow_Out,
  output logic                  Underflow_Out,
`endif
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic rd_ok, wr_ok;
  assign FIFO_Empty = count == CW'(0);
  assign FIFO_Full = count == CW'(DEPTH);
  assign rd_ok = Read_Enable_In && !FIFO_Empty;
  // a read in the same cycle frees a slot, so a full queue still takes the write
  assign wr_ok = Write_Enable_In && (!FIFO_Full || rd_ok);
  always_ff @(posedge Clk_In)
    if (wr_ok) mem[wr_ptr] <= Data_In;
  always_ff @(posedge Clk_In or posedge Reset_In)
    if (Reset_In) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      Data_Out <= '0;
    end else begin
      wr_ptr <= wr_ok ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_ok ? rd_ptr + AW'(1) : rd_ptr;
      Data_Out <= rd_ok ? mem[rd_ptr] : Data_Out;
      count <= (wr_ok && !rd_ok) ? count + CW'(1) : (rd_ok && !wr_ok) ? count - CW'(1) : count;
    end
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  always_ff @(posedge Clk_In or posedge Reset_In)
    if (Reset_In) begin
      Overflow_Out <= 1'b0;
      Underflow_Out <= 1'b0;
    end else begin
      Overflow_Out <= Write_Enable_In && !wr_ok;
      Underflow_Out <= Read_Enable_In && !rd_ok;
    end
`else
`endif
endmodule

// File: tb/tb_fifo_queue_16_bit.sv
// tb_fifo_queue_16_bit: scoreboard bench for fifo_queue_16_bit
module tb_fifo_queue_16_bit;
  logic Clk_In = 0, Reset_In = 1, Write_Enable_In = 0, Read_Enable_In = 0;
  logic [15:0] Data_In = 0, Data_Out;
  logic FIFO_Empty, FIFO_Full;
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
  logic Overflow_Out, Underflow_Out;
`endif
  typedef struct packed {logic [15:0] d; logic e, f, o, u;} rec_t;
  rec_t sb[$];
  logic [15:0] mq[$];
  logic [15:0] m_do = 0;
  int total = 0, bad = 0;
  always #5 Clk_In = ~Clk_In;
  fifo_queue_16_bit dut (
    .Clk_In(Clk_In),
    .Reset_In(Reset_In),
    .Data_In(Data_In),
    .Data_Out(Data_Out),
    .Write_Enable_In(Write_Enable_In),
    .Read_Enable_In(Read_Enable_In),
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    .Overflow_Out(Overflow_Out),
    .Underflow_Out(Underflow_Out),
`endif
    .FIFO_Empty(FIFO_Empty),
    .FIFO_Full(FIFO_Full)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  // one clock of stimulus; the expected post-edge state goes to the scoreboard
  task automatic cyc(input logic we, input logic re, input logic [15:0] d);
    logic rd, wr;
    rec_t r;
    @(negedge Clk_In);
    Write_Enable_In = we;
    Read_Enable_In = re;
    Data_In = d;
    @(posedge Clk_In);
    rd = re && mq.size() != 0;
    wr = we && (mq.size() != 8 || rd);
    if (rd) m_do = mq.pop_front();
    if (wr) mq.push_back(d);
    r.d = m_do;
    r.e = mq.size() == 0;
    r.f = mq.size() == 8;
    r.o = we && !wr;
    r.u = re && !rd;
    sb.push_back(r);
  endtask
  task automatic check_now(input string n, input logic [15:0] d, input logic e, input logic f);
    #1;
    chk({n, "_data"}, Data_Out, d);
    chk({n, "_empty"}, {15'b0, FIFO_Empty}, {15'b0, e});
    chk({n, "_full"}, {15'b0, FIFO_Full}, {15'b0, f});
  endtask
  task automatic async_reset();
    @(negedge Clk_In);
    Write_Enable_In = 0;
    Read_Enable_In = 0;
    #2 Reset_In = 1;
    check_now("async_reset", 16'h0000, 1'b1, 1'b0);
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
    chk("async_reset_ovf", {15'b0, Overflow_Out}, 16'h0);
    chk("async_reset_unf", {15'b0, Underflow_Out}, 16'h0);
`endif
    mq.delete();
    m_do = 0;
    @(negedge Clk_In);
    Reset_In = 0;
  endtask
  initial forever begin
    rec_t r;
    @(negedge Clk_In);
    if (sb.size() != 0) begin
      r = sb.pop_front();
      chk("sb_data", Data_Out, r.d);
      chk("sb_empty", {15'b0, FIFO_Empty}, {15'b0, r.e});
      chk("sb_full", {15'b0, FIFO_Full}, {15'b0, r.f});
`ifdef FIFO_QUEUE_ERR_FLAGS_EN
      chk("sb_ovf", {15'b0, Overflow_Out}, {15'b0, r.o});
      chk("sb_unf", {15'b0, Underflow_Out}, {15'b0, r.u});
`endif
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [15:0] v;
    int n;
    repeat (2) @(negedge Clk_In);
    check_now("reset", 16'h0000, 1'b1, 1'b0);
    Reset_In = 0;
    cyc(0, 1, 16'h0);
    check_now("rd_empty", 16'h0000, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      v = 16'(i * 16'h1111);
      cyc(1, 0, v);
      if (i == 1) check_now("first_wr", 16'h0000, 1'b0, 1'b0);
    end
    check_now("fill", 16'h0000, 1'b0, 1'b1);
    cyc(1, 0, 16'hDEAD);
    check_now("wr_full", 16'h0000, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 16'h0);
    check_now("drain", 16'h8888, 1'b1, 1'b0);
    cyc(0, 1, 16'h0);
    check_now("rd_after_drain", 16'h8888, 1'b1, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      v = 16'hA000 + 16'(i);
      cyc(1, 0, v);
    end
    cyc(1, 1, 16'hBEEF);
    check_now("rw_full", 16'hA001, 1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) cyc(0, 1, 16'h0);
    check_now("wrap_drain", 16'hBEEF, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      v = 16'h0C00 + 16'(i);
      cyc(1, 0, v);
    end
    async_reset();
    cyc(1, 0, 16'h1234);
    cyc(0, 1, 16'h0);
    check_now("post_reset", 16'h1234, 1'b1, 1'b0);
    cyc(1, 1, 16'h5555);
    check_now("rw_empty", 16'h1234, 1'b0, 1'b0);
    cyc(0, 1, 16'h0);
    check_now("rw_empty_rd", 16'h5555, 1'b1, 1'b0);
    cyc(0, 0, 16'h0);
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      @(negedge Clk_In);
      n++;
    end
    if (sb.size() != 0) chk("sb_drain", 16'(sb.size()), 16'h0);
    @(posedge Clk_In);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
